// File: rtl/lives_hearts_object_if.sv
// Pixel/event inputs and heart-slot geometry outputs shared between the
// VGA timing side (master) and the lives/hearts object (slave).
interface lives_hearts_object_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        hitPulse;
    logic        addLife;
    logic        newGame;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic [2:0]  livesCount;
    logic        gameOver;

    modport master (
        output pixelX, pixelY, startOfFrame, hitPulse, addLife, newGame,
        input  offsetX, offsetY, InsideRectangle, livesCount, gameOver
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, hitPulse, addLife, newGame,
        output offsetX, offsetY, InsideRectangle, livesCount, gameOver
    );
endinterface

// File: rtl/lives_hearts_object.sv
// Lives counter with post-hit invulnerability/blink FSM, plus per-pixel
// heart-slot hit test feeding the 16x16 heart bitmap (1-cycle latency).
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_ALIVE     | normal play, hits accepted
// ST_INVULN    | after a hit; hits ignored, heart just lost blinks
// ST_GAME_OVER | no lives left; only newGame leaves this state
module lives_hearts_object #(
    parameter int MAX_LIVES     = 3,
    parameter int TOP_LEFT_X    = 16,
    parameter int TOP_LEFT_Y    = 16,
    parameter int HEART_SIZE    = 16,
    parameter int SPACING       = 20,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic                  clk,
    input  logic                  resetN,
    lives_hearts_object_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_INVULN    = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    localparam logic [2:0]  MAX_L      = 3'(MAX_LIVES);
    localparam logic [7:0]  INV_LOAD   = 8'(INVULN_FRAMES);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [10:0] TOP_Y      = 11'(TOP_LEFT_Y);
    localparam logic [10:0] SIZE       = 11'(HEART_SIZE);

    state_t      state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic [7:0]  invuln_q, invuln_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_on_q, blink_on_d;
    logic [10:0] off_x_q, off_x_d;
    logic [10:0] off_y_q, off_y_d;
    logic        inside_q, inside_d;
    logic        y_in;

    function automatic logic [10:0] slot_left(input int k);
        return 11'(TOP_LEFT_X + k * SPACING);
    endfunction

    // Event handling: newGame beats hitPulse beats addLife; frame ticks run the timers.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        invuln_d    = invuln_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (bus.newGame) begin
            state_d     = ST_ALIVE;
            lives_d     = MAX_L;
            invuln_d    = 8'd0;
            blink_cnt_d = 8'd0;
            blink_on_d  = 1'b0;
        end else if (bus.hitPulse && state_q == ST_ALIVE && lives_q != 3'd0) begin
            state_d     = ST_INVULN;
            lives_d     = lives_q - 3'd1;
            invuln_d    = INV_LOAD;
            blink_cnt_d = 8'd0;
            blink_on_d  = 1'b1;
        end else begin
            // A simultaneous hit drops the bonus life even when the hit itself is ignored.
            if (bus.addLife && !bus.hitPulse && state_q != ST_GAME_OVER && lives_q < MAX_L) begin
                lives_d = lives_q + 3'd1;
            end
            if (bus.startOfFrame && state_q == ST_INVULN) begin
                if (invuln_q != 8'd0) begin
                    invuln_d = invuln_q - 8'd1;
                end
                if (blink_cnt_q >= BLINK_LAST) begin
                    blink_cnt_d = 8'd0;
                    blink_on_d  = ~blink_on_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 8'd1;
                end
                if (invuln_q <= 8'd1) begin
                    state_d = (lives_d != 3'd0) ? ST_ALIVE : ST_GAME_OVER;
                end
            end
        end
    end

    // Slot hit test against the state registered before this edge.
    always_comb begin
        inside_d = 1'b0;
        off_x_d  = 11'd0;
        off_y_d  = 11'd0;
        y_in     = (bus.pixelY >= TOP_Y) && (bus.pixelY < TOP_Y + SIZE);
        for (int k = 0; k < MAX_LIVES; k++) begin
            if (!inside_d && y_in &&
                ((3'(k) < lives_q) ||
                 (state_q == ST_INVULN && 3'(k) == lives_q && blink_on_q)) &&
                bus.pixelX >= slot_left(k) && bus.pixelX < slot_left(k) + SIZE) begin
                inside_d = 1'b1;
                off_x_d  = bus.pixelX - slot_left(k);
                off_y_d  = bus.pixelY - TOP_Y;
            end
        end
    end

    // State, timers and registered geometry outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_ALIVE;
            lives_q     <= MAX_L;
            invuln_q    <= 8'd0;
            blink_cnt_q <= 8'd0;
            blink_on_q  <= 1'b0;
            off_x_q     <= 11'd0;
            off_y_q     <= 11'd0;
            inside_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            invuln_q    <= invuln_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            off_x_q     <= off_x_d;
            off_y_q     <= off_y_d;
            inside_q    <= inside_d;
        end
    end

    assign bus.offsetX         = off_x_q;
    assign bus.offsetY         = off_y_q;
    assign bus.InsideRectangle = inside_q;
    assign bus.livesCount      = lives_q;
    assign bus.gameOver        = (state_q == ST_GAME_OVER);

endmodule

// File: doc/lives_hearts_object.md
# lives_hearts_object

Drives the heart bitmap renderer for the lives indicator in the HUD. Holds the player lives count and a post-hit invulnerability/blink state machine. For each VGA pixel it decides whether the pixel falls inside a visible heart slot, and produces the registered `offsetX`/`offsetY`/`InsideRectangle` triple that the 16x16 heart bitmap consumes. Sits between the VGA pixel counters and the heart bitmap; the bitmap's `drawingRequest`/RGB feed the HUD priority mux.

## Interface
- `MAX_LIVES`, default 3: initial and maximum lives; legal range 1..7.
- `TOP_LEFT_X`, default 16: x of slot 0 left edge.
- `TOP_LEFT_Y`, default 16: y of all slots' top edge.
- `HEART_SIZE`, default 16: slot width/height in pixels; matches the bitmap.
- `SPACING`, default 20: x pitch between slot left edges; must be ≥ HEART_SIZE.
- `INVULN_FRAMES`, default 60: frames of invulnerability after a hit; range 1..255.
- `BLINK_FRAMES`, default 8: frames per blink half-period; range 1..255.

Ports:
- `clk`  in  1  pixel clock.
- `resetN`  in  1  asynchronous active-low reset.
- `pixelX`  in  11  current pixel x.
- `pixelY`  in  11  current pixel y.
- `startOfFrame`  in  1  one-cycle pulse per frame.
- `hitPulse`  in  1  one-cycle collision pulse.
- `addLife`  in  1  one-cycle bonus-life pulse.
- `newGame`  in  1  one-cycle restart pulse.
- `offsetX`  out  11  pixel offset from the hit slot's left edge; 0 when outside.
- `offsetY`  out  11  pixel offset from `TOP_LEFT_Y`; 0 when outside.
- `InsideRectangle`  out  1  pixel is inside a visible heart slot.
- `livesCount`  out  3  current lives.
- `gameOver`  out  1  high in the GAME_OVER state.

## Operation
- States:
  - ALIVE: normal play.
  - INVULN: after a hit; further hits are ignored.
  - GAME_OVER: no lives left.
- Priority of events in one cycle: `newGame` > `hitPulse` > `addLife`. A lower-priority pulse in the same cycle is dropped.
- `newGame`, any state: lives ← MAX_LIVES, timers cleared, state ← ALIVE.
- `hitPulse` in ALIVE with lives > 0:
  - lives ← lives − 1.
  - invulnTimer ← INVULN_FRAMES.
  - blinkCnt ← 0.
  - blinkOn ← 1.
  - state ← INVULN.
- `hitPulse` in INVULN or GAME_OVER: ignored.
- `addLife` in ALIVE or INVULN: lives ← min(lives + 1, MAX_LIVES). Ignored in GAME_OVER.
- On `startOfFrame` in INVULN:
  - invulnTimer decrements.
  - blinkCnt increments; when it reaches BLINK_FRAMES − 1 it wraps to 0 and blinkOn toggles.
  - When invulnTimer goes 1 → 0, the state becomes ALIVE if lives > 0, else GAME_OVER.
- Geometry:
  - Slot k covers x ∈ [TOP_LEFT_X + k·SPACING, TOP_LEFT_X + k·SPACING + HEART_SIZE) and y ∈ [TOP_LEFT_Y, TOP_LEFT_Y + HEART_SIZE), for k = 0..MAX_LIVES−1.
  - Comparisons are unsigned, 11 bits wide.
- Visibility: slot k is visible if k < lives, or if state = INVULN, k = lives, and blinkOn = 1. The heart just lost blinks.
- When the pixel is inside a visible slot:
  - `offsetX` = pixelX − slotLeft.
  - `offsetY` = pixelY − TOP_LEFT_Y.
  - Both fit in 0..HEART_SIZE−1.
- Otherwise all three geometry outputs are 0.
- `livesCount` reflects the registered lives. `gameOver` = (state == GAME_OVER).

## Timing
- Reset values:
  - `offsetX` = 0, `offsetY` = 0, `InsideRectangle` = 0.
  - `livesCount` = MAX_LIVES, `gameOver` = 0.
  - State ALIVE, invulnTimer = 0, blinkCnt = 0, blinkOn = 0.
- Geometry outputs are registered with 1-cycle latency from `pixelX`/`pixelY`. Downstream alignment accounts for this plus the bitmap's own register stage.
- Visibility uses the state registered before the current edge. A hit at cycle t affects geometry for pixels sampled at t+1 onward.
- Lives and state update on the edge that samples the pulse. `livesCount` and `gameOver` change 1 cycle after the pulse.
- `startOfFrame` in the same cycle as `hitPulse`: the hit loads the timers; no decrement is applied that cycle.
- `startOfFrame` in the same cycle as `newGame`: `newGame` wins.
- Reset asserted mid-INVULN: returns immediately to the reset values, asynchronously.
- Lives = 0 cannot occur in ALIVE.

## Test plan
- Reset, then pixel (16,16) → next cycle `InsideRectangle`=1, offset (0,0). Pixel (51,31) → slot 1, offset (15,15). Pixel (32,16) → 0, offsets 0. `livesCount`=3.
- `hitPulse` → `livesCount`=2, state INVULN. A second `hitPulse` 5 cycles later → ignored, lives stay 2.
- During INVULN, pixel (56,16) (slot 2) → `InsideRectangle`=1 for frames 0–7 after the hit, 0 for frames 8–15, 1 for frames 16–23. After 60 frames → ALIVE and slot 2 is hidden.
- Three hits, each after its invulnerability expires → `livesCount`=0. `gameOver`=1 on the edge after the 60th frame following the last hit. Further hit and addLife → no change.
- At 3 lives, `addLife` → stays 3. Hit then addLife → 3. `hitPulse` and `addLife` in the same cycle → 2.
- `newGame` mid-INVULN with lives 1 → `livesCount`=3, `gameOver`=0, no blink. Asserting `resetN` low mid-frame → all outputs return to their reset values without a clock edge.
